// File: rtl/vram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vram_pkg                                                             |
// | Shared types and sizes for the video RAM port-B line fetcher.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    localparam int VRAM_ADDR_W = 10;
    localparam int VRAM_DATA_W = 8;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo                                                           |
// | Small FIFO with registered head, flush and same-cycle push/pop.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               w_do_pop;
    logic               w_do_push;

    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        w_do_pop  = i_pop && (count_q != '0);
        // when full, the popped slot is the one being written, so order holds
        w_do_push = i_push && ((count_q != c_cnt_w'(DEPTH)) || w_do_pop);
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) begin
                mem_d[wr_ptr_q] = i_data;
                wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_d = count_q + c_cnt_w'(1);
                2'b01:   count_d = count_q - c_cnt_w'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_valid = (count_q != '0);
    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/vram_line_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vram_line_fetch                                                      |
// | Credit-flow-controlled burst reader from VRAM port B into a FIFO.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vram_line_fetch
    import vram_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_q,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  remaining_q, remaining_d;
    logic               inflight_q, inflight_d;
    logic               w_rd;
    logic               w_pop;
    logic               w_credit_ok;
    logic [c_cnt_w-1:0] w_fifo_count;
    logic [c_cnt_w:0]   w_need;

    // occupancy after this cycle's pop, plus the read landing next cycle, plus the new one
    assign w_pop       = out_valid && out_ready;
    assign w_need      = {1'b0, w_fifo_count} - {{c_cnt_w{1'b0}}, w_pop}
                       + {{c_cnt_w{1'b0}}, inflight_q} + (c_cnt_w+1)'(1);
    assign w_credit_ok = (w_need <= (c_cnt_w+1)'(FIFO_DEPTH));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        w_rd        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = len;
                    state_d     = (len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (w_credit_ok) begin
                    w_rd        = 1'b1;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                    if (remaining_q == ADDR_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((remaining_q == '0) && !inflight_q && (w_fifo_count == '0)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d     = IDLE;
            addr_d      = addr_q;
            remaining_d = '0;
            w_rd        = 1'b0;
        end
        inflight_d = w_rd;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_flush (abort),
        .i_push  (inflight_q && !abort),
        .i_data  (ram_q),
        .i_pop   (w_pop),
        .o_valid (out_valid),
        .o_head  (out_data),
        .o_count (w_fifo_count)
    );

    assign ram_addr = addr_q;
    assign ram_rd   = w_rd;
    assign busy     = (state_q == FETCH) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_vram_line_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vram_line_fetch                                                   |
// | Scoreboard bench: RAM model, directed transfers, abort and reset.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vram_line_fetch;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [9:0] base_addr;
    logic [9:0] len;
    logic       busy;
    logic       done;
    logic [9:0] ram_addr;
    logic       ram_rd;
    logic [7:0] ram_q;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    logic [7:0] mem [1024];
    logic [9:0] exp_addr[$];
    logic [7:0] exp_data[$];

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_rd   = 0;
    int n_pop  = 0;
    int n_done = 0;
    logic [7:0] last_data = 8'h00;

    vram_line_fetch #(
        .ADDR_W     (10),
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_rd    (ram_rd),
        .ram_q     (ram_q),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    end

    always @(posedge clock) begin
        if (ram_rd) ram_q <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: compare every issued read and every popped byte against the queues
    always @(negedge clock) begin
        if (ram_rd === 1'b1) begin
            n_rd++;
            if (exp_addr.size() == 0) chk("unexpected_read", exp_addr.size(), 1);
            else chk("ram_addr", {22'd0, ram_addr}, {22'd0, exp_addr.pop_front()});
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_pop++;
            last_data = out_data;
            if (exp_data.size() == 0) chk("unexpected_pop", exp_data.size(), 1);
            else chk("out_data", {24'd0, out_data}, {24'd0, exp_data.pop_front()});
        end
        if (done === 1'b1) n_done++;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic start_xfer(input logic [9:0] b, input logic [9:0] l);
        logic [9:0] a;
        for (int i = 0; i < int'(l); i++) begin
            a = 10'(int'(b) + i);
            exp_addr.push_back(a);
            exp_data.push_back(a[7:0] ^ 8'h5A);
        end
        cyc();
        base_addr = b;
        len       = l;
        start     = 1'b1;
        cyc();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, r0, p0;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; len = '0; out_ready = 1'b0;
        #2;
        chk("reset_outputs", {busy, done, ram_rd, out_valid, ram_addr, out_data}, 32'd0);
        repeat (3) cyc();
        reset_n = 1'b1;
        cyc();

        // 1: basic 3-byte transfer with latency checks
        out_ready = 1'b1;
        d0 = n_done;
        start_xfer(10'h010, 10'd3);
        @(negedge clock);
        chk("t1_first_rd", {ram_rd, ram_addr}, {1'b1, 10'h010});
        @(negedge clock);
        chk("t1_valid_c2", {31'd0, out_valid}, 32'd0);
        @(negedge clock);
        chk("t1_valid_c3", {31'd0, out_valid}, 32'd1);
        wait_done(50, "t1_done");
        chk("t1_busy_in_done", {31'd0, busy}, 32'd0);
        @(negedge clock);
        chk("t1_after_done", {done, busy}, 2'b00);
        chk("t1_one_done", n_done - d0, 1);
        chk("t1_all_bytes", exp_data.size() + exp_addr.size(), 0);
        chk("t1_last", {24'd0, last_data}, 32'h48);

        // 2: address wrap
        start_xfer(10'h3FE, 10'd4);
        wait_done(50, "t2_done");
        chk("t2_all_bytes", exp_data.size() + exp_addr.size(), 0);
        chk("t2_last", {24'd0, last_data}, 32'h5B);

        // 3: backpressure fills the FIFO exactly
        out_ready = 1'b0;
        r0 = n_rd; p0 = n_pop;
        start_xfer(10'h100, 10'd8);
        repeat (20) @(negedge clock);
        chk("t3_reads_stalled", n_rd - r0, 4);
        chk("t3_no_pops", n_pop - p0, 0);
        chk("t3_rd_low_full", {ram_rd, out_valid}, 2'b01);
        cyc();
        out_ready = 1'b1;
        wait_done(100, "t3_done");
        chk("t3_all_bytes", n_pop - p0, 8);
        chk("t3_queue_empty", exp_data.size() + exp_addr.size(), 0);

        // 4: zero-length transfer
        r0 = n_rd;
        start_xfer(10'h055, 10'd0);
        @(negedge clock);
        chk("t4_done_next", {done, busy}, 2'b10);
        @(negedge clock);
        chk("t4_no_read", n_rd - r0, 0);
        chk("t4_no_valid_done", {out_valid, done}, 2'b00);

        // 5: abort after the fifth pop
        p0 = n_pop;
        start_xfer(10'h020, 10'd16);
        for (int k = 0; k < 100 && (n_pop - p0) < 5; k++) cyc();
        chk("t5_reached_5", ((n_pop - p0) >= 5) ? 1 : 0, 1);
        d0 = n_done;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        @(negedge clock);
        chk("t5_after_abort", {busy, out_valid, ram_rd}, 3'b000);
        repeat (5) @(negedge clock);
        chk("t5_no_done", n_done - d0, 0);
        p0 = n_pop;
        start_xfer(10'h000, 10'd1);
        wait_done(50, "t5_restart_done");
        chk("t5_single_byte", n_pop - p0, 1);
        chk("t5_byte_val", {24'd0, last_data}, 32'h5A);

        // 6: second start ignored, then reset mid-transfer
        p0 = n_pop;
        start_xfer(10'h040, 10'd8);
        cyc();
        base_addr = 10'h200; len = 10'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 100 && (n_pop - p0) < 3; k++) cyc();
        chk("t6_busy_mid", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_reset_outputs", {busy, done, ram_rd, out_valid, ram_addr, out_data}, 32'd0);
        exp_addr.delete();
        exp_data.delete();
        cyc();
        cyc();
        reset_n = 1'b1;
        p0 = n_pop;
        start_xfer(10'h3FF, 10'd2);
        wait_done(50, "t6_post_reset_done");
        chk("t6_post_bytes", n_pop - p0, 2);
        chk("t6_queue_empty", exp_data.size() + exp_addr.size(), 0);

        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
